// File: rtl/painter_pkg.sv
// painter_pkg: opcodes, command lengths and FSM states
// shared by the painter command fetch unit and the painter engine top.
package painter_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PLOT = 2'b01,
    OP_FILL = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT1,
    S_WAIT2,
    S_EXEC
  } state_e;

  localparam logic [1:0] LEN_NOP  = 2'd1;
  localparam logic [1:0] LEN_PLOT = 2'd2;
  localparam logic [1:0] LEN_FILL = 2'd3;
  localparam logic [1:0] LEN_SWAP = 2'd1;

  function automatic logic [1:0] cmd_len(op_e op);
    logic [1:0] len;
    unique case (op)
      OP_NOP:  len = LEN_NOP;
      OP_PLOT: len = LEN_PLOT;
      OP_FILL: len = LEN_FILL;
      OP_SWAP: len = LEN_SWAP;
      default: len = LEN_NOP;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/painter_cmd_fetch.sv
// painter_cmd_fetch: ring read pointer, occupancy, cmd RAM addressing.
// In: wrt_ptr, start_i/adv_i/done_i, len_i. Out: rd_ptr_o, cmd_addr_o,
// empty_o, full_o, avail_o (ring holds >= len_i words from rd_ptr).
module painter_cmd_fetch
  import painter_pkg::*;
#(
  parameter int PTR_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] wrt_ptr,
  input  logic             start_i,
  input  logic             adv_i,
  input  logic             done_i,
  input  logic [1:0]       len_i,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] cmd_addr_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             avail_o
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [PTR_W-1:0] occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      idx_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
    end
  end

  // idx selects the word being read this cycle; start_i reads
  // word1 speculatively so it is ready right after word0.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    if (done_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(len_i);
      idx_d    = '0;
    end else if (start_i) begin
      idx_d = 2'd1;
    end else if (adv_i) begin
      idx_d = idx_q + 2'd1;
    end
  end

  assign occ        = wrt_ptr - rd_ptr_q;
  assign avail_o    = occ >= PTR_W'(len_i);
  assign empty_o    = wrt_ptr == rd_ptr_q;
  assign full_o     = (wrt_ptr + PTR_W'(1)) == rd_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign cmd_addr_o = rd_ptr_q + PTR_W'(idx_q);

endmodule

// File: rtl/painter_engine.sv
// painter_engine: command-ring painter (NOP/PLOT/FILL/SWAP) to back FB.
// In: wrtPtr, PRAMdata, vblank. Out: cmdAddr, rdPtr, full, addr/data/we,
// swapBuffers, busy.
module painter_engine
  import painter_pkg::*;
#(
  parameter int PTR_W  = 10,
  parameter int CMD_W  = 16,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PTR_W-1:0]  wrtPtr,
  input  logic [CMD_W-1:0]  PRAMdata,
  input  logic              vblank,
  output logic [PTR_W-1:0]  cmdAddr,
  output logic [PTR_W-1:0]  rdPtr,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data,
  output logic              we,
  output logic              swapBuffers,
  output logic              busy
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [PIX_W-1:0]  col_q, col_d;
  logic [1:0]        len_q, len_d;
  logic              ok_q, ok_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  logic       start, adv, done, empty, avail;
  logic [1:0] len_cur;
  op_e        w_op;

  assign w_op = op_e'(PRAMdata[CMD_W-1 -: 2]);

  painter_cmd_fetch #(.PTR_W(PTR_W)) u_fetch (
    .clk        (clk),
    .reset      (reset),
    .wrt_ptr    (wrtPtr),
    .start_i    (start),
    .adv_i      (adv),
    .done_i     (done),
    .len_i      (len_cur),
    .rd_ptr_o   (rdPtr),
    .cmd_addr_o (cmdAddr),
    .empty_o    (empty),
    .full_o     (full),
    .avail_o    (avail)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      col_q   <= '0;
      len_q   <= '0;
      ok_q    <= 1'b0;
      pix_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      len_q   <= len_d;
      ok_q    <= ok_d;
      pix_q   <= pix_d;
      rem_q   <= rem_d;
    end
  end

  // ok_q: word1 read last cycle was inside the filled part of the ring.
  // Checking the full length there also covers word2 of a FILL.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    col_d   = col_q;
    len_d   = len_q;
    ok_d    = ok_q;
    pix_d   = pix_q;
    rem_d   = rem_q;
    len_cur = len_q;
    start   = 1'b0;
    adv     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          start   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op_d    = w_op;
        col_d   = PRAMdata[PIX_W-1:0];
        len_cur = cmd_len(w_op);
        len_d   = len_cur;
        ok_d    = avail;
        if (len_cur == 2'd1) begin
          state_d = S_EXEC;
        end else begin
          adv     = avail;
          state_d = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (ok_q) begin
          pix_d   = PRAMdata[ADDR_W-1:0];
          state_d = (op_q == OP_FILL) ? S_WAIT2 : S_EXEC;
        end else begin
          ok_d = avail;
          adv  = avail;
        end
      end
      S_WAIT2: begin
        rem_d   = PRAMdata[ADDR_W-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op_q)
          OP_FILL: begin
            if (rem_q != '0) begin
              pix_d = pix_q + ADDR_W'(1);
              rem_d = rem_q - ADDR_W'(1);
            end
            done = rem_q <= ADDR_W'(1);
          end
          OP_SWAP: done = vblank;
          default: done = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (done) state_d = S_IDLE;
  end

  always_comb begin
    we          = 1'b0;
    swapBuffers = 1'b0;
    addr        = '0;
    data        = '0;
    busy        = state_q != S_IDLE;
    unique case (1'b1)
      state_q == S_EXEC && op_q == OP_PLOT: we = 1'b1;
      state_q == S_EXEC && op_q == OP_FILL: we = rem_q != '0;
      state_q == S_EXEC && op_q == OP_SWAP: swapBuffers = vblank;
      default: ;
    endcase
    if (we) begin
      addr = pix_q;
      data = col_q;
    end
  end

endmodule

// File: tb/tb_painter_engine.sv
// tb_painter_engine: directed bench for painter_engine with a
// synchronous command RAM model and a write/swap logger.
module tb_painter_engine;
  localparam int PTR_W  = 10;
  localparam int CMD_W  = 16;
  localparam int ADDR_W = 15;
  localparam int PIX_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vblank = 1'b0;
  logic [PTR_W-1:0]  wrtPtr = '0;
  logic [CMD_W-1:0]  PRAMdata = '0;
  logic [PTR_W-1:0]  cmdAddr, rdPtr;
  logic              full, we, swapBuffers, busy;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  data;

  logic [CMD_W-1:0]  ram [0:(1<<PTR_W)-1];
  logic [PTR_W-1:0]  wp = '0;

  int cyc = 0;
  int npass = 0;
  int ntot = 0;
  int nfail = 0;
  int t0, tv, b, bs;
  int swap_n = 0;
  int swap_cyc = -1;
  int w_cyc[$];
  logic [ADDR_W-1:0] w_addr[$];
  logic [PIX_W-1:0]  w_data[$];
  logic [ADDR_W-1:0] exp_a [4];

  painter_engine #(
    .PTR_W(PTR_W), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .reset(reset), .wrtPtr(wrtPtr), .PRAMdata(PRAMdata),
    .vblank(vblank), .cmdAddr(cmdAddr), .rdPtr(rdPtr), .full(full),
    .addr(addr), .data(data), .we(we), .swapBuffers(swapBuffers),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    PRAMdata <= ram[cmdAddr];
  end

  always @(negedge clk) begin
    if (we) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(addr);
      w_data.push_back(data);
    end
    if (swapBuffers) begin
      swap_n   <= swap_n + 1;
      swap_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [CMD_W-1:0] w);
    ram[wp] = w;
    wp = wp + 1'b1;
  endtask

  task automatic go();
    wrtPtr = wp;
    t0 = cyc;
    b = w_addr.size();
  endtask

  task automatic wait_rd(input logic [PTR_W-1:0] tgt, input int lim,
                         input string tag);
    int n = 0;
    while ((rdPtr !== tgt || busy !== 1'b0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rdPtr), 32'(tgt));
  endtask

  initial begin
    for (int i = 0; i < (1 << PTR_W); i++) ram[i] = '0;

    // 1: reset
    reset = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_swap", 32'(swapBuffers), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdptr", 32'(rdPtr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_cmdaddr", 32'(cmdAddr), 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // 2: PLOT colour 5 at 0x1234
    put(16'h4005);
    put(16'h1234);
    go();
    wait_rd(10'd2, 20, "plot_rd");
    chk("plot_n", 32'(w_addr.size() - b), 1);
    chk("plot_addr", 32'(w_addr[b]), 32'h1234);
    chk("plot_data", 32'(w_data[b]), 5);
    chk("plot_lat", 32'(w_cyc[b] - t0), 3);
    tick(2);
    chk("plot_idle", 32'(busy), 0);

    // 3: FILL wrapping 0x7FFE, count 4
    put(16'h8003);
    put(16'h7FFE);
    put(16'h0004);
    go();
    wait_rd(10'd5, 30, "fill_rd");
    chk("fill_n", 32'(w_addr.size() - b), 4);
    exp_a[0] = 15'h7FFE;
    exp_a[1] = 15'h7FFF;
    exp_a[2] = 15'h0000;
    exp_a[3] = 15'h0001;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_addr%0d", k), 32'(w_addr[b+k]), 32'(exp_a[k]));
      chk($sformatf("fill_data%0d", k), 32'(w_data[b+k]), 3);
      chk($sformatf("fill_cyc%0d", k), 32'(w_cyc[b+k] - t0), 32'(4 + k));
    end
    tick(1);
    put(16'h8003);
    put(16'h0100);
    put(16'h0000);
    go();
    wait_rd(10'd8, 30, "fill0_rd");
    chk("fill0_n", 32'(w_addr.size() - b), 0);
    tick(1);
    put(16'h0000);
    go();
    wait_rd(10'd9, 20, "nop_rd");
    chk("nop_n", 32'(w_addr.size() - b), 0);

    // 4: SWAP waits for vblank
    tick(1);
    bs = swap_n;
    put(16'hC000);
    go();
    repeat (50) @(negedge clk);
    chk("swap_wait_n", 32'(swap_n - bs), 0);
    chk("swap_wait_busy", 32'(busy), 1);
    chk("swap_wait_rd", 32'(rdPtr), 9);
    tick(1);
    vblank = 1'b1;
    tv = cyc;
    @(negedge clk);
    chk("swap_pulse", 32'(swapBuffers), 1);
    chk("swap_rd_hold", 32'(rdPtr), 9);
    tick(1);
    chk("swap_rd_adv", 32'(rdPtr), 10);
    repeat (3) @(negedge clk);
    chk("swap_once", 32'(swap_n - bs), 1);
    chk("swap_cyc", 32'(swap_cyc), 32'(tv));
    tick(1);
    put(16'hC000);
    go();
    wait_rd(10'd11, 20, "swapvb_rd");
    chk("swapvb_lat", 32'(swap_cyc - t0), 2);
    chk("swapvb_n", 32'(swap_n - bs), 2);
    vblank = 1'b0;

    // 5: walk to slot 1023, FILL straddling the wrap, ring full
    tick(1);
    wp = 10'd1023;
    go();
    wait_rd(10'd1023, 5000, "walk_rd");
    tick(1);
    for (int i = 2; i < 1022; i++) ram[i] = '0;
    ram[1023] = 16'h8006;
    ram[0]    = 16'h0010;
    ram[1]    = 16'h0002;
    wp = 10'd1022;
    go();
    @(negedge clk);
    chk("wrap_full", 32'(full), 1);
    wait_rd(10'd2, 30, "wrap_rd");
    chk("wrap_full_clr", 32'(full), 0);
    chk("wrap_n", 32'(w_addr.size() - b), 2);
    chk("wrap_addr0", 32'(w_addr[b]), 32'h0010);
    chk("wrap_addr1", 32'(w_addr[b+1]), 32'h0011);
    chk("wrap_data", 32'(w_data[b]), 6);
    wait_rd(10'd1022, 5000, "drain_rd");

    // 6: reset in the middle of a long FILL
    tick(1);
    ram[1022] = 16'h8007;
    ram[1023] = 16'h0200;
    ram[0]    = 16'h0064;
    wp = 10'd1;
    go();
    for (int n = 0; n < 40 && (w_addr.size() - b) < 10; n++)
      @(negedge clk);
    chk("mid_run", 32'((w_addr.size() - b) >= 10), 1);
    chk("mid_addr0", 32'(w_addr[b]), 32'h0200);
    chk("mid_addr9", 32'(w_addr[b+9]), 32'h0209);
    chk("mid_data", 32'(w_data[b+9]), 7);
    tick(1);
    reset  = 1'b1;
    wrtPtr = '0;
    tick(1);
    @(negedge clk);
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_rd", 32'(rdPtr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    b = w_addr.size();
    repeat (5) @(negedge clk);
    chk("post_rst_n", 32'(w_addr.size() - b), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
